sha256_nonce_seq: RTL

Job sequencer directly upstream of the windowed SHA-256 compression core. It issues the core's command stream (load H, hash, sum-and-store) for a Bitcoin-style double SHA-256 over an 80-byte header. It selects which H and M memory banks feed the core for each command and iterates a nonce range. Each final hash is compared against a 256-bit target, and the sequencer reports the first passing nonce.

---
 rtl/sha256_pkg.sv | 79 +++++++
 rtl/sha256_nonce_seq_if.sv | 23 ++
 rtl/sha256_tgt_cmp.sv | 23 ++
 rtl/sha256_nonce_seq.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared definitions for the double-SHA-256 nonce sequencer and its compression core.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
// Contents: cmd_t (core command codes, shared with the core), H/M bank select codes,
// state_t (sequencer states), drive_t (registered core-side outputs) and helpers that
// map a command state to its drive values and to its successor.
package sha256_pkg;

  typedef enum logic [7:0] {
    CMD_IDLE        = 8'd0,
    CMD_LOAD_H      = 8'd1,
    CMD_HASH        = 8'd2,
    CMD_SUM_STORE_H = 8'd3,
    CMD_SUM_STORE_M = 8'd4
  } cmd_t;

  localparam logic       HSEL_IV     = 1'b0;
  localparam logic       HSEL_MID    = 1'b1;
  localparam logic [1:0] MSEL_STATIC = 2'd0;
  localparam logic [1:0] MSEL_DYN    = 2'd1;
  localparam logic [1:0] MSEL_HASH   = 2'd2;

  typedef enum logic [3:0] {
    IDLE, MID_LOAD, MID_HASH, MID_STORE,
    B2_LOAD, B2_HASH, B2_STORE,
    B3_LOAD, B3_HASH, CHECK, NEXT
  } state_t;

  typedef struct packed {
    cmd_t       cmd;
    logic       h_sel;
    logic [1:0] m_sel;
    logic       h_we;
    logic       m_we;
  } drive_t;

  localparam drive_t DRIVE_IDLE = '{cmd: CMD_IDLE, h_sel: HSEL_IV, m_sel: MSEL_STATIC,
                                    h_we: 1'b0, m_we: 1'b0};

  // Drive values for the ISSUE phase of a state. Selects a state does not care about
  // keep their current value so the banks never toggle needlessly.
  function automatic drive_t issue_drive(state_t s, logic h_cur, logic [1:0] m_cur);
    drive_t d;
    d.cmd   = CMD_IDLE;
    d.h_sel = h_cur;
    d.m_sel = m_cur;
    d.h_we  = 1'b0;
    d.m_we  = 1'b0;
    case (s)
      MID_LOAD:  begin d.cmd = CMD_LOAD_H; d.h_sel = HSEL_IV; d.m_sel = MSEL_STATIC; end
      MID_HASH:  begin d.cmd = CMD_HASH; d.m_sel = MSEL_STATIC; end
      MID_STORE: begin d.cmd = CMD_SUM_STORE_H; d.h_sel = HSEL_MID; d.h_we = 1'b1; end
      B2_LOAD:   begin d.cmd = CMD_LOAD_H; d.h_sel = HSEL_MID; end
      B2_HASH:   begin d.cmd = CMD_HASH; d.m_sel = MSEL_DYN; end
      B2_STORE:  begin
        d.cmd = CMD_SUM_STORE_M; d.h_sel = HSEL_MID; d.m_sel = MSEL_HASH; d.m_we = 1'b1;
      end
      B3_LOAD:   begin d.cmd = CMD_LOAD_H; d.h_sel = HSEL_IV; end
      B3_HASH:   begin d.cmd = CMD_HASH; d.m_sel = MSEL_HASH; end
      default:   ;
    endcase
    return d;
  endfunction

  function automatic state_t next_cmd_state(state_t s);
    case (s)
      MID_LOAD:  return MID_HASH;
      MID_HASH:  return MID_STORE;
      MID_STORE: return B2_LOAD;
      B2_LOAD:   return B2_HASH;
      B2_HASH:   return B2_STORE;
      B2_STORE:  return B3_LOAD;
      B3_LOAD:   return B3_HASH;
      B3_HASH:   return CHECK;
      default:   return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/sha256_nonce_seq_if.sv
// Sequencer <-> compression core command bus.
// Latency: n/a (wires only).
// Backpressure: core holds RDY high to complete a command and must drop it before the next.
// master (sequencer): drives CMD, H_SEL, M_SEL, H_WE, M_WE, NONCE; samples RDY, RES.
// slave (core): the reverse.
interface sha256_nonce_seq_if #(
  parameter int NONCE_W = 32
);
  import sha256_pkg::*;

  cmd_t               CMD;
  logic               RDY;
  logic [255:0]       RES;
  logic               H_SEL;
  logic [1:0]         M_SEL;
  logic               H_WE;
  logic               M_WE;
  logic [NONCE_W-1:0] NONCE;

  modport master (output CMD, H_SEL, M_SEL, H_WE, M_WE, NONCE, input RDY, RES);
  modport slave  (input CMD, H_SEL, M_SEL, H_WE, M_WE, NONCE, output RDY, RES);

endinterface

// File: rtl/sha256_tgt_cmp.sv
// Difficulty check: byte-reverse the core's final hash and test it unsigned <= target.
// Latency: combinational.
// Backpressure: none.
// Ports: res (core digest, byte order as produced), target (big-endian numeric), pass.
module sha256_tgt_cmp (
  input  logic [255:0] res,
  input  logic [255:0] target,
  output logic         pass
);

  logic [255:0] res_rev;

  // The digest's first byte is the least significant byte of the numeric hash value.
  always_comb begin
    res_rev = '0;
    for (int i = 0; i < 32; i++) begin
      res_rev[8*i +: 8] = res[8*(31-i) +: 8];
    end
  end

  assign pass = (res_rev <= target);

endmodule

// File: rtl/sha256_nonce_seq.sv
// Double-SHA-256 job sequencer: issues LOAD_H/HASH/SUM_STORE commands per nonce, reports first pass.
// Latency: all outputs registered; a command appears on the edge after START / after RDY is seen low.
// Backpressure: each command waits for RDY=1, then idles until RDY=0 before the next one.
// Ports: CLK, RST (sync, active-high); START, NONCE_START, NONCE_END, TARGET (job request);
// core (sha256_nonce_seq_if.master); BUSY, DONE, FOUND, FOUND_NONCE (job status).
// Build option: SHA256_MIDSTATE_REUSE_EN computes the first-block midstate once per job.
module sha256_nonce_seq
  import sha256_pkg::*;
#(
  parameter int NONCE_W = 32
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                START,
  input  logic [NONCE_W-1:0]  NONCE_START,
  input  logic [NONCE_W-1:0]  NONCE_END,
  input  logic [255:0]        TARGET,
  sha256_nonce_seq_if.master  core,
  output logic                BUSY,
  output logic                DONE,
  output logic                FOUND,
  output logic [NONCE_W-1:0]  FOUND_NONCE
);

`ifdef SHA256_MIDSTATE_REUSE_EN
  localparam state_t LOOP_STATE = B2_LOAD;
`else
  localparam state_t LOOP_STATE = MID_LOAD;
`endif

  state_t             state_q, state_d;
  logic               release_q, release_d;   // 0: ISSUE phase, 1: RELEASE phase
  drive_t             drv_q, drv_d;
  logic [NONCE_W-1:0] nonce_q, nonce_d;
  logic [NONCE_W-1:0] nonce_end_q, nonce_end_d;
  logic [255:0]       target_q, target_d;
  logic [255:0]       res_q, res_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               found_q, found_d;
  logic [NONCE_W-1:0] found_nonce_q, found_nonce_d;
  logic               pass;

  sha256_tgt_cmp u_tgt_cmp (
    .res    (res_q),
    .target (target_q),
    .pass   (pass)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= IDLE;
      release_q     <= 1'b0;
      drv_q         <= DRIVE_IDLE;
      nonce_q       <= '0;
      nonce_end_q   <= '0;
      target_q      <= '0;
      res_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      found_q       <= 1'b0;
      found_nonce_q <= '0;
    end else begin
      state_q       <= state_d;
      release_q     <= release_d;
      drv_q         <= drv_d;
      nonce_q       <= nonce_d;
      nonce_end_q   <= nonce_end_d;
      target_q      <= target_d;
      res_q         <= res_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      found_q       <= found_d;
      found_nonce_q <= found_nonce_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    release_d     = release_q;
    drv_d         = drv_q;
    nonce_d       = nonce_q;
    nonce_end_d   = nonce_end_q;
    target_d      = target_q;
    res_d         = res_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    found_d       = found_q;
    found_nonce_d = found_nonce_q;

    case (state_q)
      IDLE: begin
        if (START) begin
          nonce_d       = NONCE_START;
          nonce_end_d   = NONCE_END;
          target_d      = TARGET;
          found_d       = 1'b0;
          found_nonce_d = '0;
          busy_d        = 1'b1;
          state_d       = MID_LOAD;
          release_d     = 1'b0;
          drv_d         = issue_drive(MID_LOAD, drv_q.h_sel, drv_q.m_sel);
        end
      end

      CHECK: begin
        if (pass) begin
          found_d       = 1'b1;
          found_nonce_d = nonce_q;
          busy_d        = 1'b0;
          done_d        = 1'b1;
          state_d       = IDLE;
        end else begin
          state_d = NEXT;
        end
      end

      NEXT: begin
        if (nonce_q == nonce_end_q) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          // Natural wrap of the NONCE_W-bit add lets a range run through all-ones to zero.
          nonce_d   = nonce_q + NONCE_W'(1);
          state_d   = LOOP_STATE;
          release_d = 1'b0;
          drv_d     = issue_drive(LOOP_STATE, drv_q.h_sel, drv_q.m_sel);
        end
      end

      default: begin
        // Command states: ISSUE holds the command until RDY, RELEASE idles until RDY drops.
        if (!release_q) begin
          if (core.RDY) begin
            release_d  = 1'b1;
            drv_d.cmd  = CMD_IDLE;
            drv_d.h_we = 1'b0;
            drv_d.m_we = 1'b0;
            if (state_q == B3_HASH) begin
              res_d = core.RES;
            end
          end
        end else if (!core.RDY) begin
          state_d   = next_cmd_state(state_q);
          release_d = 1'b0;
          drv_d     = issue_drive(next_cmd_state(state_q), drv_q.h_sel, drv_q.m_sel);
        end
      end
    endcase
  end

  assign core.CMD   = drv_q.cmd;
  assign core.H_SEL = drv_q.h_sel;
  assign core.M_SEL = drv_q.m_sel;
  assign core.H_WE  = drv_q.h_we;
  assign core.M_WE  = drv_q.m_we;
  assign core.NONCE = nonce_q;

  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign FOUND       = found_q;
  assign FOUND_NONCE = found_nonce_q;

endmodule
